// File: rtl/imem_fetch_responder.sv
// Word-addressed instruction store answering one fetch at a time over valid/ready,
// with LATENCY wait states, fault tagging for misaligned/out-of-range PCs and a load port.
module imem_fetch_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_ReqValid_1,
  output logic                  o_ReqReady_1,
  input  logic [31:0]           i_ReqAddr_32,
  output logic                  o_RspValid_1,
  input  logic                  i_RspReady_1,
  output logic [31:0]           o_RspInst_32,
  output logic [31:0]           o_RspAddr_32,
  output logic [1:0]            o_RspFault_2,
  input  logic                  i_LoadEn_1,
  input  logic [DEPTH_LOG2-1:0] i_LoadAddr,
  input  logic [31:0]           i_LoadData_32,
  output logic                  o_Busy_1
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]            req_fault;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Store has no reset so boot-loaded contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (i_LoadEn_1) mem_q[i_LoadAddr] <= i_LoadData_32;
  end

  assign req_fault[0] = |i_ReqAddr_32[1:0];
  assign req_fault[1] = |(i_ReqAddr_32 >> (DEPTH_LOG2 + 2));
  assign rd_idx       = rsp_addr_q[DEPTH_LOG2+1:2];

  // The accept edge only captures the request; WAIT always spends one cycle with
  // the counter at zero before the registered store read, so the response lands
  // LATENCY+1 edges after accept (LATENCY=0 still gives one cycle).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      IDLE: begin
        if (i_ReqValid_1) begin
          state_d     = WAIT;
          cnt_d       = LAT4;
          rsp_addr_d  = i_ReqAddr_32;
          rsp_fault_d = req_fault;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          // Combinational read here against the NBA write gives read-before-write.
          rsp_inst_d  = (|rsp_fault_q) ? FAULT_INST : mem_q[rd_idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_RspReady_1) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= 32'd0;
      rsp_addr_q  <= 32'd0;
      rsp_fault_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign o_ReqReady_1 = (state_q == IDLE);
  assign o_Busy_1     = (state_q != IDLE);
  assign o_RspValid_1 = rsp_valid_q;
  assign o_RspInst_32 = rsp_inst_q;
  assign o_RspAddr_32 = rsp_addr_q;
  assign o_RspFault_2 = rsp_fault_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: three instances (LATENCY 1, 0, 5) sharing the
// address/load buses, checked against an array model of the store.
module tb_imem_fetch_responder;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [31:0]  req_addr;
  logic [31:0]  rinst [N];
  logic [31:0]  raddr [N];
  logic [1:0]   rfault [N];
  logic         load_en;
  logic [9:0]   load_addr;
  logic [31:0]  load_data;

  logic [31:0] model [1024];
  int vectors = 0;
  int errs = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH_LOG2(10),
      .LATENCY   (g == 0 ? 1 : (g == 1 ? 0 : 5)),
      .FAULT_INST(32'h0000_0013)
    ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_ReqValid_1 (req_valid[g]),
      .o_ReqReady_1 (req_ready[g]),
      .i_ReqAddr_32 (req_addr),
      .o_RspValid_1 (rsp_valid[g]),
      .i_RspReady_1 (rsp_ready[g]),
      .o_RspInst_32 (rinst[g]),
      .o_RspAddr_32 (raddr[g]),
      .o_RspFault_2 (rfault[g]),
      .i_LoadEn_1   (load_en),
      .i_LoadAddr   (load_addr),
      .i_LoadData_32(load_data),
      .o_Busy_1     (busy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en = 1'b1; load_addr = 10'(idx); load_data = data;
    cyc();
    load_en = 1'b0;
    model[idx] = data;
  endtask

  // Expected response derived from address arithmetic alone.
  function automatic logic [31:0] exp_inst_of(input logic [31:0] addr);
    if ((addr % 4) != 0 || addr >= 32'd4096) return 32'h0000_0013;
    return model[(addr / 4) % 1024];
  endfunction

  task automatic fetch(input int k, input logic [31:0] addr, input int hold,
                       input bit collide, input logic [31:0] cdata);
    int n;
    int b;
    logic [31:0] e_inst;
    logic [1:0]  e_f;
    b = 0;
    while (!req_ready[k] && b < 20) begin cyc(); b++; end
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_addr = addr; rsp_ready[k] = 1'b0;
    cyc();
    req_valid[k] = 1'b0;
    e_f[0] = (addr % 4) != 0;
    e_f[1] = addr >= 32'd4096;
    e_inst = exp_inst_of(addr);
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      chk("busy_not_ready", {30'd0, busy[k], req_ready[k]}, 32'd2);
      e_inst = exp_inst_of(addr);
      if (collide && n == lat_of(k)) begin
        load_en = 1'b1; load_addr = addr[11:2]; load_data = cdata;
      end
      cyc(); n++;
      if (load_en) begin load_en = 1'b0; model[load_addr] = load_data; end
    end
    chk("latency", 32'(n), 32'(lat_of(k) + 1));
    chk("rsp_inst", rinst[k], e_inst);
    chk("rsp_addr", raddr[k], addr);
    chk("rsp_fault", {30'd0, rfault[k]}, {30'd0, e_f});
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1; req_addr = addr ^ 32'h40;
      cyc();
      chk("bp_valid", {30'd0, rsp_valid[k], req_ready[k]}, 32'd2);
      chk("bp_inst", rinst[k], e_inst);
      chk("bp_addr", raddr[k], addr);
      chk("bp_fault", {30'd0, rfault[k]}, {30'd0, e_f});
    end
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    cyc();
    rsp_ready[k] = 1'b0;
    chk("release", {29'd0, rsp_valid[k], req_ready[k], busy[k]}, 32'd2);
  endtask

  initial begin
    logic [31:0] a;
    req_valid = '0; rsp_ready = '0; req_addr = 32'd0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 32'd0;

    // Fill the whole store while reset is held.
    for (int i = 0; i < 1024; i++) load_word(i, $urandom);
    load_word(0, 32'h0050_0093);
    load_word(1, 32'h00A0_0113);
    load_word(3, 32'h0000_0033);

    for (int k = 0; k < N; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_valid_busy", {30'd0, rsp_valid[k], busy[k]}, 32'd0);
      chk("rst_inst", rinst[k], 32'd0);
      chk("rst_addr", raddr[k], 32'd0);
      chk("rst_fault", {30'd0, rfault[k]}, 32'd0);
    end
    rstn = 1'b1;
    cyc();

    fetch(0, 32'h0, 0, 1'b0, 32'd0);
    fetch(0, 32'h4, 0, 1'b0, 32'd0);
    fetch(1, 32'h8, 0, 1'b0, 32'd0);
    fetch(2, 32'h8, 0, 1'b0, 32'd0);
    fetch(0, 32'h10, 7, 1'b0, 32'd0);

    fetch(0, 32'h0000_0006, 0, 1'b0, 32'd0);
    fetch(0, 32'h0000_1000, 0, 1'b0, 32'd0);
    fetch(0, 32'h0000_1002, 0, 1'b0, 32'd0);

    fetch(0, 32'hC, 0, 1'b1, 32'hDEAD_BEEF);
    chk("collide_model", model[3], 32'hDEAD_BEEF);
    fetch(0, 32'hC, 0, 1'b0, 32'd0);

    // Abort an in-flight LATENCY=5 fetch with reset two cycles after accept.
    req_valid[2] = 1'b1; req_addr = 32'h0;
    cyc();
    req_valid[2] = 1'b0;
    cyc(); cyc();
    chk("pre_rst_busy", 32'(busy[2]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_async", {29'd0, rsp_valid[2], req_ready[2], busy[2]}, 32'd2);
    cyc(); cyc();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("midrst_no_rsp", {29'd0, rsp_valid[2], req_ready[2], busy[2]}, 32'd2);
    end
    fetch(2, 32'h0, 0, 1'b0, 32'd0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) load_word(int'($urandom_range(0, 1023)), $urandom);
      case ($urandom_range(0, 3))
        0, 1:    a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        2:       a = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        default: a = $urandom;
      endcase
      fetch(int'($urandom_range(0, N - 1)), a, int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
